// File: rtl/motor_pkg.sv
// Shared states, bridge drive patterns and helper functions for the PWM motor driver.
package motor_pkg;

    typedef enum logic [2:0] {
        STOP     = 3'd0,
        FORWARD  = 3'd1,
        BACKWARD = 3'd2,
        LEFT     = 3'd3,
        RIGHT    = 3'd4,
        BRAKE    = 3'd5
    } motor_state_t;

    // Bridge pin order is A0 A1 B0 B1; reversing swaps the A and B pairs.
    localparam logic [3:0] FWD_A = 4'b0110;
    localparam logic [3:0] FWD_B = 4'b1001;
    localparam logic [3:0] REV_A = {FWD_A[1:0], FWD_A[3:2]};
    localparam logic [3:0] REV_B = {FWD_B[1:0], FWD_B[3:2]};

    function automatic logic is_forward_group(input motor_state_t s);
        return (s == FORWARD) || (s == LEFT) || (s == RIGHT);
    endfunction

    function automatic logic is_moving(input motor_state_t s);
        return is_forward_group(s) || (s == BACKWARD);
    endfunction

    function automatic logic is_reversal(input motor_state_t from_s, input motor_state_t to_s);
        return ((from_s == BACKWARD) && is_forward_group(to_s)) ||
               ((to_s == BACKWARD) && is_forward_group(from_s));
    endfunction

    // Returns {m1, m2} for a state with the PWM enable high.
    function automatic logic [7:0] drive_pattern(input motor_state_t s);
        logic [7:0] p;
        p = 8'h00;
        case (s)
            FORWARD:  p = {FWD_A, FWD_B};
            BACKWARD: p = {REV_A, REV_B};
            LEFT:     p = {4'b0000, FWD_B};
            RIGHT:    p = {FWD_A, 4'b0000};
            default:  p = 8'h00;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/pwm_gen.sv
// Free-running PWM counter: enable while counter < duty, plus a period-end strobe.
module pwm_gen #(
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PWM_W-1:0] duty,
    output logic             pwm_en,
    output logic             wrap
);

    logic [PWM_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + PWM_W'(1);
        end
    end

    assign pwm_en = (cnt_reg < duty);
    assign wrap   = &cnt_reg;

endmodule

// File: rtl/pwm_motor_driver.sv
// Dual H-bridge driver with PWM speed, soft-start ramp, reversal dead-time brake and command watchdog.
module pwm_motor_driver
    import motor_pkg::*;
#(
    parameter int PWM_W          = 8,
    parameter int RAMP_STEP      = 4,
    parameter int DEAD_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fwd_in,
    input  logic             bwd_in,
    input  logic             left_in,
    input  logic             right_in,
    input  logic             stop_in,
    input  logic [PWM_W-1:0] speed_in,
    input  logic             ld_left,
    input  logic             ld_right,
    output logic [3:0]       m1_out,
    output logic [3:0]       m2_out,
    output logic [2:0]       state,
    output logic             timeout_out
);

    localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);
    localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);

    motor_state_t      state_reg, state_next, req;
    logic [DEAD_W-1:0] dead_cnt_reg, dead_cnt_next;
    logic [WD_W-1:0]   wd_cnt_reg, wd_cnt_next;
    logic [4:0]        cmd, cmd_prev_reg;
    logic              cmd_changed;
    logic              timeout_reg, timeout_next, timeout_active;
    logic [PWM_W-1:0]  duty_reg, duty_next;
    logic [PWM_W:0]    ramp_sum;
    logic [3:0]        m1_reg, m1_next, m2_reg, m2_next;
    logic [7:0]        drive;
    logic              pwm_en, wrap;

    pwm_gen #(.PWM_W(PWM_W)) u_pwm (
        .clk    (clk),
        .rst    (rst),
        .duty   (duty_reg),
        .pwm_en (pwm_en),
        .wrap   (wrap)
    );

    assign cmd         = {fwd_in, bwd_in, left_in, right_in, stop_in};
    assign cmd_changed = (cmd != cmd_prev_reg);
    // A command change releases the watchdog in the same cycle it appears.
    assign timeout_active = timeout_reg && !cmd_changed;

    always_comb begin
        req = STOP;
        if (stop_in || timeout_active) begin
            req = STOP;
        end else if (fwd_in) begin
            if (!ld_left) begin
                req = RIGHT;
            end else if (!ld_right) begin
                req = LEFT;
            end else begin
                req = FORWARD;
            end
        end else if (bwd_in) begin
            req = BACKWARD;
        end else if (right_in) begin
            req = RIGHT;
        end else if (left_in) begin
            req = LEFT;
        end
    end

    // Leaving BRAKE always takes the live request, so a second reversal never re-brakes.
    always_comb begin
        state_next    = req;
        dead_cnt_next = '0;
        if (state_reg == BRAKE) begin
            if (req == STOP) begin
                state_next = STOP;
            end else if (dead_cnt_reg == DEAD_W'(DEAD_CYCLES - 1)) begin
                state_next = req;
            end else begin
                state_next    = BRAKE;
                dead_cnt_next = dead_cnt_reg + DEAD_W'(1);
            end
        end else if (is_reversal(state_reg, req)) begin
            state_next = BRAKE;
        end
    end

    always_comb begin
        wd_cnt_next  = wd_cnt_reg + WD_W'(1);
        timeout_next = timeout_reg || (wd_cnt_reg == WD_W'(TIMEOUT_CYCLES - 1));
        if (cmd_changed || (req == STOP)) begin
            wd_cnt_next = '0;
        end
        if (cmd_changed) begin
            timeout_next = 1'b0;
        end
    end

    always_comb begin
        duty_next = duty_reg;
        ramp_sum  = {1'b0, duty_reg} + (PWM_W + 1)'(RAMP_STEP);
        if (!is_moving(state_reg)) begin
            duty_next = '0;
        end else if (wrap) begin
            if (duty_reg < speed_in) begin
                duty_next = (ramp_sum > {1'b0, speed_in}) ? speed_in : ramp_sum[PWM_W-1:0];
            end else begin
                duty_next = speed_in;
            end
        end
    end

    assign drive = drive_pattern(state_reg);

    for (genvar gi = 0; gi < 4; gi++) begin : g_gate
        assign m1_next[gi] = pwm_en & drive[gi + 4];
        assign m2_next[gi] = pwm_en & drive[gi];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= STOP;
            dead_cnt_reg <= '0;
            wd_cnt_reg   <= '0;
            cmd_prev_reg <= '0;
            timeout_reg  <= 1'b0;
            duty_reg     <= '0;
            m1_reg       <= '0;
            m2_reg       <= '0;
        end else begin
            state_reg    <= state_next;
            dead_cnt_reg <= dead_cnt_next;
            wd_cnt_reg   <= wd_cnt_next;
            cmd_prev_reg <= cmd;
            timeout_reg  <= timeout_next;
            duty_reg     <= duty_next;
            m1_reg       <= m1_next;
            m2_reg       <= m2_next;
        end
    end

    assign m1_out      = m1_reg;
    assign m2_out      = m2_reg;
    assign state       = state_reg;
    assign timeout_out = timeout_active;

endmodule

// File: tb/tb_pwm_motor_driver.sv
// Directed scenarios for pwm_motor_driver with PWM_W=4, RAMP_STEP=4, DEAD_CYCLES=3, TIMEOUT_CYCLES=50.
module tb_pwm_motor_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fwd_in = 1'b0, bwd_in = 1'b0, left_in = 1'b0, right_in = 1'b0, stop_in = 1'b0;
    logic [3:0] speed_in = 4'd0;
    logic       ld_left = 1'b1, ld_right = 1'b1;
    logic [3:0] m1_out, m2_out;
    logic [2:0] state;
    logic       timeout_out;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic kick_en = 1'b0;

    pwm_motor_driver #(
        .PWM_W(4), .RAMP_STEP(4), .DEAD_CYCLES(3), .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk), .rst(rst),
        .fwd_in(fwd_in), .bwd_in(bwd_in), .left_in(left_in), .right_in(right_in), .stop_in(stop_in),
        .speed_in(speed_in), .ld_left(ld_left), .ld_right(ld_right),
        .m1_out(m1_out), .m2_out(m2_out), .state(state), .timeout_out(timeout_out)
    );

    always #5 clk = ~clk;

    // cyc tracks the PWM counter phase: counter == cyc % 16 after each tick.
    // kick_en toggles left_in under a higher-priority fwd_in to keep the watchdog fed.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) cyc = 0;
        else cyc++;
        if (kick_en) left_in = ~left_in;
    endtask

    task automatic test_reset();
        fwd_in = 1'b1; speed_in = 4'd12; rst = 1'b1;
        tick(); tick();
        total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
        total++; if (m1_out !== 4'b0000) begin bad++; $display("FAIL reset_m1 got=%b exp=0000", m1_out); end
        total++; if (m2_out !== 4'b0000) begin bad++; $display("FAIL reset_m2 got=%b exp=0000", m2_out); end
        total++; if (timeout_out !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", timeout_out); end
        $display("reset: state=%0d m1=%b m2=%b", state, m1_out, m2_out);
    endtask

    task automatic test_ramp();
        int exp_on[4] = '{4, 8, 12, 12};
        int n_on;
        int n_bad;
        rst = 1'b0; kick_en = 1'b1;
        repeat (16) tick();
        total++; if (state !== 3'd1) begin bad++; $display("FAIL ramp_state got=%0d exp=1", state); end
        for (int p = 0; p < 4; p++) begin
            n_on = 0; n_bad = 0;
            repeat (16) begin
                tick();
                if (m1_out === 4'b0110 && m2_out === 4'b1001) n_on++;
                else if (m1_out !== 4'b0000 || m2_out !== 4'b0000) n_bad++;
            end
            total++; if (n_on !== exp_on[p]) begin bad++; $display("FAIL ramp_on_p%0d got=%0d exp=%0d", p, n_on, exp_on[p]); end
            total++; if (n_bad !== 0) begin bad++; $display("FAIL ramp_pattern_p%0d got=%0d exp=0", p, n_bad); end
            $display("ramp period %0d: on=%0d", p, n_on);
        end
    endtask

    task automatic test_reversal();
        int n_on;
        kick_en = 1'b0; left_in = 1'b0; fwd_in = 1'b0; bwd_in = 1'b1;
        tick();
        total++; if (state !== 3'd5) begin bad++; $display("FAIL rev_brake1 got=%0d exp=5", state); end
        tick();
        total++; if (state !== 3'd5) begin bad++; $display("FAIL rev_brake2 got=%0d exp=5", state); end
        total++; if ({m1_out, m2_out} !== 8'h00) begin bad++; $display("FAIL rev_out2 got=%b exp=00000000", {m1_out, m2_out}); end
        tick();
        total++; if (state !== 3'd5) begin bad++; $display("FAIL rev_brake3 got=%0d exp=5", state); end
        total++; if ({m1_out, m2_out} !== 8'h00) begin bad++; $display("FAIL rev_out3 got=%b exp=00000000", {m1_out, m2_out}); end
        tick();
        total++; if (state !== 3'd2) begin bad++; $display("FAIL rev_backward got=%0d exp=2", state); end
        total++; if ({m1_out, m2_out} !== 8'h00) begin bad++; $display("FAIL rev_out4 got=%b exp=00000000", {m1_out, m2_out}); end
        do tick(); while (cyc % 16 != 0);
        n_on = 0;
        repeat (16) begin
            tick();
            if (m1_out === 4'b1001 && m2_out === 4'b0110) n_on++;
        end
        total++; if (n_on !== 4) begin bad++; $display("FAIL rev_duty_restart got=%0d exp=4", n_on); end
        $display("reversal: backward on=%0d", n_on);
    endtask

    task automatic test_line_steering();
        kick_en = 1'b1; fwd_in = 1'b1; bwd_in = 1'b0;
        repeat (4) tick();
        total++; if (state !== 3'd1) begin bad++; $display("FAIL steer_forward got=%0d exp=1", state); end
        do tick(); while (cyc % 16 != 0);
        ld_left = 1'b0;
        tick();
        total++; if (state !== 3'd4) begin bad++; $display("FAIL steer_right got=%0d exp=4", state); end
        tick();
        total++; if (m1_out !== 4'b0110) begin bad++; $display("FAIL steer_right_m1 got=%b exp=0110", m1_out); end
        total++; if (m2_out !== 4'b0000) begin bad++; $display("FAIL steer_right_m2 got=%b exp=0000", m2_out); end
        ld_left = 1'b1; ld_right = 1'b0;
        tick();
        total++; if (state !== 3'd3) begin bad++; $display("FAIL steer_left got=%0d exp=3", state); end
        tick();
        total++; if (m1_out !== 4'b0000) begin bad++; $display("FAIL steer_left_m1 got=%b exp=0000", m1_out); end
        total++; if (m2_out !== 4'b1001) begin bad++; $display("FAIL steer_left_m2 got=%b exp=1001", m2_out); end
        $display("steering: state=%0d m1=%b m2=%b", state, m1_out, m2_out);
    endtask

    task automatic test_watchdog();
        kick_en = 1'b0; left_in = 1'b0; ld_right = 1'b1; stop_in = 1'b1;
        tick();
        total++; if (state !== 3'd0) begin bad++; $display("FAIL wd_prestop got=%0d exp=0", state); end
        stop_in = 1'b0;
        tick();
        total++; if (state !== 3'd1) begin bad++; $display("FAIL wd_forward got=%0d exp=1", state); end
        repeat (49) tick();
        total++; if (timeout_out !== 1'b0) begin bad++; $display("FAIL wd_early got=%b exp=0", timeout_out); end
        total++; if (state !== 3'd1) begin bad++; $display("FAIL wd_still_fwd got=%0d exp=1", state); end
        tick();
        total++; if (timeout_out !== 1'b1) begin bad++; $display("FAIL wd_expire got=%b exp=1", timeout_out); end
        tick();
        total++; if (state !== 3'd0) begin bad++; $display("FAIL wd_stop got=%0d exp=0", state); end
        tick();
        total++; if ({m1_out, m2_out} !== 8'h00) begin bad++; $display("FAIL wd_out got=%b exp=00000000", {m1_out, m2_out}); end
        fwd_in = 1'b0; left_in = 1'b1;
        tick();
        total++; if (timeout_out !== 1'b0) begin bad++; $display("FAIL wd_clear got=%b exp=0", timeout_out); end
        total++; if (state !== 3'd3) begin bad++; $display("FAIL wd_resume got=%0d exp=3", state); end
        $display("watchdog: timeout=%b state=%0d", timeout_out, state);
    endtask

    task automatic test_stop_priority();
        fwd_in = 1'b1; stop_in = 1'b1; left_in = 1'b0;
        tick();
        total++; if (state !== 3'd0) begin bad++; $display("FAIL stop_state got=%0d exp=0", state); end
        tick();
        total++; if ({m1_out, m2_out} !== 8'h00) begin bad++; $display("FAIL stop_out got=%b exp=00000000", {m1_out, m2_out}); end
        total++; if (timeout_out !== 1'b0) begin bad++; $display("FAIL stop_timeout got=%b exp=0", timeout_out); end
        $display("stop priority: state=%0d", state);
    endtask

    task automatic test_reset_mid_brake();
        stop_in = 1'b0; fwd_in = 1'b1;
        tick();
        total++; if (state !== 3'd1) begin bad++; $display("FAIL rstb_forward got=%0d exp=1", state); end
        fwd_in = 1'b0; bwd_in = 1'b1;
        tick();
        total++; if (state !== 3'd5) begin bad++; $display("FAIL rstb_brake got=%0d exp=5", state); end
        rst = 1'b1;
        tick();
        total++; if (state !== 3'd0) begin bad++; $display("FAIL rstb_state got=%0d exp=0", state); end
        total++; if ({m1_out, m2_out} !== 8'h00) begin bad++; $display("FAIL rstb_out got=%b exp=00000000", {m1_out, m2_out}); end
        rst = 1'b0;
        tick();
        total++; if (state !== 3'd2) begin bad++; $display("FAIL rstb_direct_bwd got=%0d exp=2", state); end
        repeat (15) tick();
        total++; if (m1_out !== 4'b0000) begin bad++; $display("FAIL rstb_duty_zero got=%b exp=0000", m1_out); end
        tick();
        total++; if (m1_out !== 4'b1001) begin bad++; $display("FAIL rstb_first_on_m1 got=%b exp=1001", m1_out); end
        total++; if (m2_out !== 4'b0110) begin bad++; $display("FAIL rstb_first_on_m2 got=%b exp=0110", m2_out); end
        $display("reset mid-brake: state=%0d m1=%b", state, m1_out);
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_reversal();
        test_line_steering();
        test_watchdog();
        test_stop_priority();
        test_reset_mid_brake();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
